// File: rtl/strobe_sync_rx.sv
// Multi-channel toggle-strobe receiver: synchronises per-channel request toggles,
// holds one word per channel and round-robins them into a single ready/valid output.
// Define STROBE_DUP_EN to add out_strobe_dup, three preserved copies of out_strobe.
module strobe_sync_rx #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req_tgl,
    input  logic [CHANNELS*WIDTH-1:0] req_data,
    output logic [CHANNELS-1:0]       ack_tgl,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [2:0]                out_chan,
    output logic                      out_strobe,
`ifdef STROBE_DUP_EN
    output logic [2:0]                out_strobe_dup,
`endif
    output logic [CHANNELS-1:0]       overrun,
    input  logic                      overrun_clr
);

    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, HELD} ch_state_e;

    ch_state_e                state_q [CHANNELS];
    ch_state_e                state_d [CHANNELS];
    logic [SYNC_STAGES-1:0]   sync_q  [CHANNELS];
    logic [SYNC_STAGES-1:0]   sync_d  [CHANNELS];
    logic [WIDTH-1:0]         hold_q  [CHANNELS];
    logic [WIDTH-1:0]         hold_d  [CHANNELS];
    logic [CHANNELS-1:0]      ref_q, ref_d, ack_q, ack_d, ovr_q, ovr_d;
    logic [CHANNELS-1:0]      evt, xfer;
    logic [CW-1:0]            last_q, last_d, grant;
    logic                     any_pend, load;
    logic                     out_valid_q, out_valid_d, strobe_q, strobe_d;
    logic [WIDTH-1:0]         out_data_q, out_data_d;
    logic [2:0]               out_chan_q, out_chan_d;

    // Round-robin search starts one past the last grant.
    always_comb begin
        any_pend = 1'b0;
        grant    = last_q;
        for (int i = 1; i <= CHANNELS; i++) begin
            if (!any_pend && state_q[(int'(last_q) + i) % CHANNELS] == HELD) begin
                grant    = CW'((int'(last_q) + i) % CHANNELS);
                any_pend = 1'b1;
            end
        end
        load = (!out_valid_q || out_ready) && any_pend;
    end

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            sync_d[c]  = {sync_q[c][SYNC_STAGES-2:0], req_tgl[c]};
            ref_d[c]   = sync_q[c][SYNC_STAGES-1];
            evt[c]     = sync_q[c][SYNC_STAGES-1] ^ ref_q[c];
            xfer[c]    = load && (grant == CW'(c));
            state_d[c] = state_q[c];
            hold_d[c]  = hold_q[c];
            ack_d[c]   = ack_q[c] ^ xfer[c];
            ovr_d[c]   = ovr_q[c] & ~overrun_clr;
            // A new event beats a simultaneous clear; an event during transfer refills the slot.
            if (evt[c]) begin
                if (state_q[c] == HELD && !xfer[c]) begin
                    ovr_d[c] = 1'b1;
                end else begin
                    state_d[c] = HELD;
                    hold_d[c]  = req_data[c*WIDTH +: WIDTH];
                end
            end else if (xfer[c]) begin
                state_d[c] = IDLE;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        strobe_d    = out_valid_q && out_ready;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q[grant];
            out_chan_d  = 3'(grant);
            last_d      = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= IDLE;
                sync_q[c]  <= '0;
                hold_q[c]  <= '0;
            end
            ref_q       <= '0;
            ack_q       <= '0;
            ovr_q       <= '0;
            last_q      <= CW'(CHANNELS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            strobe_q    <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= state_d[c];
                sync_q[c]  <= sync_d[c];
                hold_q[c]  <= hold_d[c];
            end
            ref_q       <= ref_d;
            ack_q       <= ack_d;
            ovr_q       <= ovr_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            strobe_q    <= strobe_d;
        end
    end

    assign ack_tgl    = ack_q;
    assign overrun    = ovr_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chan   = out_chan_q;
    assign out_strobe = strobe_q;

`ifdef STROBE_DUP_EN
    // Separate copies so each downstream load group gets its own driver.
    (* preserve_signal *) logic [2:0] strobe_dup_q;
    logic [2:0] strobe_dup_d;

    always_comb strobe_dup_d = {3{strobe_d}};

    always_ff @(posedge clk) begin
        if (rst) strobe_dup_q <= '0;
        else     strobe_dup_q <= strobe_dup_d;
    end

    assign out_strobe_dup = strobe_dup_q;
`endif

endmodule

// File: tb/tb_strobe_sync_rx.sv
// Directed bench for strobe_sync_rx; expected words go into a scoreboard queue
// and a negedge monitor pops and compares on every accepted output word.
module tb_strobe_sync_rx;
    localparam int CH = 4;
    localparam int W  = 8;
    localparam int SS = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [CH-1:0]    req_tgl = '0;
    logic [CH*W-1:0]  req_data = '0;
    logic [CH-1:0]    ack_tgl;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [2:0]       out_chan;
    logic             out_strobe;
    logic [CH-1:0]    overrun;
    logic             overrun_clr = 1'b0;
`ifdef STROBE_DUP_EN
    logic [2:0]       out_strobe_dup;
`endif

    strobe_sync_rx #(.CHANNELS(CH), .WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .req_tgl(req_tgl), .req_data(req_data),
        .ack_tgl(ack_tgl), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_chan(out_chan), .out_strobe(out_strobe),
`ifdef STROBE_DUP_EN
        .out_strobe_dup(out_strobe_dup),
`endif
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int accepts  = 0;
    int strobes  = 0;
    logic [10:0] sb [$];
    logic [10:0] exp_w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_strobe) strobes++;
            if (out_valid && out_ready) begin
                accepts++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got chan %0d data %0h expected none", out_chan, out_data);
                end else begin
                    exp_w = sb.pop_front();
                    chk("word", 32'({out_chan, out_data}), 32'(exp_w));
                end
            end
`ifdef STROBE_DUP_EN
            chk("strobe_dup", 32'(out_strobe_dup), 32'({3{out_strobe}}));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [CH-1:0] tgl_during);
        rst         = 1'b1;
        sb.delete();
        req_tgl     = tgl_during;
        out_ready   = 1'b0;
        overrun_clr = 1'b0;
        cyc(3);
        rst = 1'b0;
    endtask

    task automatic tgl(input int c, input logic [7:0] d, input bit expect_out);
        req_data[c*W +: W] = d;
        req_tgl[c]         = ~req_tgl[c];
        if (expect_out) sb.push_back({3'(c), d});
    endtask

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!out_valid && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"},  32'(out_valid),  32'd0);
        chk({nm, "_data"},   32'(out_data),   32'd0);
        chk({nm, "_chan"},   32'(out_chan),   32'd0);
        chk({nm, "_ack"},    32'(ack_tgl),    32'd0);
        chk({nm, "_strobe"}, 32'(out_strobe), 32'd0);
        chk({nm, "_ovr"},    32'(overrun),    32'd0);
    endtask

    initial begin
        int n;
        int a0;
        int s0;

        // Reset state
        do_reset('0);
        chk_zero("rst");

        // Single word on channel 0, latency and handshake
        out_ready = 1'b1;
        a0 = accepts;
        s0 = strobes;
        tgl(0, 8'hA5, 1);
        wait_valid(20, n);
        chk("latency", 32'(n), 32'(SS + 2));
        chk("c0_data", 32'(out_data), 32'h A5);
        chk("c0_chan", 32'(out_chan), 32'd0);
        chk("c0_ack", 32'(ack_tgl), 32'b0001);
        cyc(3);
        chk("c0_strobes", 32'(strobes - s0), 32'd1);
        chk("c0_accepts", 32'(accepts - a0), 32'd1);
        chk("c0_valid_drop", 32'(out_valid), 32'd0);

        // All four channels at once: back-to-back words 0..3
        do_reset('0);
        out_ready = 1'b1;
        a0 = accepts;
        s0 = strobes;
        for (int c = 0; c < CH; c++) tgl(c, 8'(8'h10 + c), 1);
        wait_valid(20, n);
        for (int k = 0; k < CH; k++) begin
            chk("burst_no_bubble", 32'(out_valid), 32'd1);
            cyc(1);
        end
        chk("burst_end_valid", 32'(out_valid), 32'd0);
        chk("burst_ack", 32'(ack_tgl), 32'hF);
        cyc(1);
        chk("burst_accepts", 32'(accepts - a0), 32'd4);
        chk("burst_strobes", 32'(strobes - s0), 32'd4);

        // Backpressure: word must stay stable until accepted
        do_reset('0);
        a0 = accepts;
        tgl(2, 8'h33, 1);
        wait_valid(20, n);
        for (int k = 0; k < 10; k++) begin
            chk("stall_data", 32'({out_chan, out_data}), 32'({3'd2, 8'h33}));
            cyc(1);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("stall_valid_drop", 32'(out_valid), 32'd0);
        chk("stall_strobe", 32'(out_strobe), 32'd1);
        cyc(1);
        chk("stall_strobe_once", 32'(out_strobe), 32'd0);
        chk("stall_accepts", 32'(accepts - a0), 32'd1);

        // Overrun: slot and hold both full, third toggle dropped
        do_reset('0);
        a0 = accepts;
        tgl(1, 8'h01, 1);
        wait_valid(20, n);
        tgl(1, 8'h02, 1);
        cyc(SS + 3);
        chk("ovr_none_yet", 32'(overrun), 32'd0);
        tgl(1, 8'h03, 0);
        cyc(SS + 3);
        chk("ovr_set", 32'(overrun), 32'b0010);
        chk("ovr_slot_kept", 32'(out_data), 32'h01);
        out_ready = 1'b1;
        cyc(5);
        chk("ovr_accepts", 32'(accepts - a0), 32'd2);
        chk("ovr_sb_empty", 32'(sb.size()), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'b0010);
        overrun_clr = 1'b1;
        cyc(1);
        overrun_clr = 1'b0;
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Reset with three channels pending: nothing stale may emerge
        do_reset('0);
        for (int c = 0; c < 3; c++) tgl(c, 8'(8'hC0 + c), 1);
        wait_valid(20, n);
        cyc(1);
        do_reset('0);
        chk_zero("midrst");
        a0 = accepts;
        out_ready = 1'b1;
        cyc(10);
        chk("midrst_no_words", 32'(accepts - a0), 32'd0);
        tgl(3, 8'h77, 1);
        wait_valid(20, n);
        chk("midrst_c3", 32'({out_chan, out_data}), 32'({3'd3, 8'h77}));
        cyc(2);
        chk("midrst_sb_empty", 32'(sb.size()), 32'd0);

        // Toggle held high through reset yields exactly one event
        req_data[7:0] = 8'h5C;
        do_reset(4'b0001);
        sb.push_back({3'd0, 8'h5C});
        a0 = accepts;
        out_ready = 1'b1;
        wait_valid(20, n);
        cyc(20);
        chk("held_tgl_accepts", 32'(accepts - a0), 32'd1);
        chk("held_tgl_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
